// File: rtl/ibex_data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ibex_data_bus_arbiter
// Description : Shares one req/gnt/rvalid data-memory port between the core
//               LSU (host 0) and a debug/DMA master (host 1). Requests are
//               routed combinationally. An in-order ID FIFO returns each
//               response to the host that issued it. A per-host lock keeps
//               both halves of a misaligned access back-to-back.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_data_bus_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter bit          FIXED_PRIO      = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        h0_req_i,
    input  logic        h0_lock_i,
    input  logic [31:0] h0_addr_i,
    input  logic        h0_we_i,
    input  logic [3:0]  h0_be_i,
    input  logic [31:0] h0_wdata_i,
    output logic        h0_gnt_o,
    output logic        h0_rvalid_o,
    output logic        h0_err_o,
    output logic [31:0] h0_rdata_o,
    input  logic        h1_req_i,
    input  logic        h1_lock_i,
    input  logic [31:0] h1_addr_i,
    input  logic        h1_we_i,
    input  logic [3:0]  h1_be_i,
    input  logic [31:0] h1_wdata_i,
    output logic        h1_gnt_o,
    output logic        h1_rvalid_o,
    output logic        h1_err_o,
    output logic [31:0] h1_rdata_o,
    output logic        d_req_o,
    output logic [31:0] d_addr_o,
    output logic        d_we_o,
    output logic [3:0]  d_be_o,
    output logic [31:0] d_wdata_o,
    input  logic        d_gnt_i,
    input  logic        d_rvalid_i,
    input  logic        d_err_i,
    input  logic [31:0] d_rdata_i,
    output logic        resp_err_o
);

    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_IDX = PW'(MAX_OUTSTANDING - 1);

    // Arbitration state
    logic                       rr_q, rr_d;
    logic                       lock_q, lock_d;
    logic                       lock_owner_q, lock_owner_d;
    logic                       held_q, held_d;
    logic                       held_sel_q, held_sel_d;
    // Outstanding-transaction ID FIFO
    logic [MAX_OUTSTANDING-1:0] ids_q, ids_d;
    logic [PW-1:0]              wptr_q, wptr_d;
    logic [PW-1:0]              rptr_q, rptr_d;
    logic [CW-1:0]              cnt_q, cnt_d;

    logic sel;
    logic sel_req;
    logic full;
    logic gnt;
    logic pop;
    logic head;

    assign full = (cnt_q == FULL_CNT);
    assign head = ids_q[rptr_q];
    assign pop  = d_rvalid_i & (cnt_q != '0);

    // Pick the host that owns the device port this cycle
    always_comb begin
        sel     = 1'b0;
        sel_req = 1'b0;
        if (held_q) begin
            // an ungranted request must stay on the bus unchanged
            sel     = held_sel_q;
            sel_req = held_sel_q ? h1_req_i : h0_req_i;
        end else if (lock_q) begin
            // the other host is ignored while a lock is active
            sel     = lock_owner_q;
            sel_req = lock_owner_q ? h1_req_i : h0_req_i;
        end else begin
            sel_req = h0_req_i | h1_req_i;
            if (h0_req_i && h1_req_i) begin
                sel = FIXED_PRIO ? 1'b0 : rr_q;
            end else begin
                sel = h1_req_i;
            end
        end
    end

    // Request mux towards the device and grant fan-back; no issue when full
    always_comb begin
        d_req_o   = sel_req & ~full;
        d_addr_o  = sel ? h1_addr_i  : h0_addr_i;
        d_we_o    = sel ? h1_we_i    : h0_we_i;
        d_be_o    = sel ? h1_be_i    : h0_be_i;
        d_wdata_o = sel ? h1_wdata_i : h0_wdata_i;
        gnt       = d_req_o & d_gnt_i;
        h0_gnt_o  = gnt & ~sel;
        h1_gnt_o  = gnt & sel;
    end

    // Response routing by the oldest outstanding ID
    always_comb begin
        h0_rvalid_o = pop & ~head;
        h1_rvalid_o = pop & head;
        h0_err_o    = pop & ~head & d_err_i;
        h1_err_o    = pop & head & d_err_i;
        h0_rdata_o  = d_rdata_i;
        h1_rdata_o  = d_rdata_i;
        resp_err_o  = d_rvalid_i & (cnt_q == '0);
    end

    // Next-state for arbitration, lock and FIFO bookkeeping
    always_comb begin
        rr_d         = rr_q;
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        held_d       = d_req_o & ~d_gnt_i;
        held_sel_d   = sel;
        ids_d        = ids_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        cnt_d        = cnt_q;

        if (gnt) begin
            rr_d          = ~sel;
            ids_d[wptr_q] = sel;
            wptr_d        = (wptr_q == LAST_IDX) ? '0 : wptr_q + 1'b1;
            if (sel ? h1_lock_i : h0_lock_i) begin
                lock_d       = 1'b1;
                lock_owner_d = sel;
            end else if (lock_q && (lock_owner_q == sel)) begin
                lock_d       = 1'b0;
            end
        end
        if (pop) begin
            rptr_d = (rptr_q == LAST_IDX) ? '0 : rptr_q + 1'b1;
        end
        // count moves only when exactly one of push/pop happens
        if (gnt && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !gnt) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q         <= 1'b0;
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
            held_q       <= 1'b0;
            held_sel_q   <= 1'b0;
            ids_q        <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
        end else begin
            rr_q         <= rr_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            held_q       <= held_d;
            held_sel_q   <= held_sel_d;
            ids_q        <= ids_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule
`default_nettype wire
